// File: rtl/dec_pkg.sv
// Shared definitions for the age-based deflection router: field positions,
// port indices and default parameter values.
package dec_pkg;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  typedef enum logic [2:0] {
    PORT_N = 3'(P_N),
    PORT_E = 3'(P_E),
    PORT_S = 3'(P_S),
    PORT_W = 3'(P_W),
    PORT_L = 3'(P_L)
  } port_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_X_W    = 2;
  localparam int DEF_Y_W    = 2;
  localparam int DEF_CORD_X = 1;
  localparam int DEF_CORD_Y = 1;
  localparam int DEF_AGE_W  = 4;
  localparam int DEF_CNT_W  = 16;

  // Flit layout, MSB to LSB: {valid, age, dst_x, dst_y, payload}
  function automatic int dst_y_lo(int data_w);
    return data_w;
  endfunction

  function automatic int dst_x_lo(int data_w, int y_w);
    return data_w + y_w;
  endfunction

  function automatic int age_lo(int data_w, int x_w, int y_w);
    return data_w + y_w + x_w;
  endfunction

  function automatic int valid_pos(int data_w, int age_w, int x_w, int y_w);
    return data_w + y_w + x_w + age_w;
  endfunction

  function automatic int flit_w(int data_w, int age_w, int x_w, int y_w);
    return 1 + age_w + x_w + y_w + data_w;
  endfunction

endpackage

// File: rtl/dec_router_age_if.sv
// Link bundle between the router and its neighbours / local endpoint.
interface dec_router_age_if #(
  parameter int FLIT_W = dec_pkg::flit_w(dec_pkg::DEF_DATA_W, dec_pkg::DEF_AGE_W,
                                         dec_pkg::DEF_X_W, dec_pkg::DEF_Y_W),
  parameter int CNT_W  = dec_pkg::DEF_CNT_W
);
  logic [FLIT_W-1:0] dinN, dinE, dinS, dinW;
  logic [FLIT_W-1:0] doutN, doutE, doutS, doutW, doutLocal;
  logic [FLIT_W-1:0] inj_flit;
  logic              inj_valid;
  logic              inj_ready;
  logic              defl_clr;
  logic [CNT_W-1:0]  defl_cnt;

  modport master (
    output dinN, dinE, dinS, dinW, inj_flit, inj_valid, defl_clr,
    input  doutN, doutE, doutS, doutW, doutLocal, inj_ready, defl_cnt
  );

  modport slave (
    input  dinN, dinE, dinS, dinW, inj_flit, inj_valid, defl_clr,
    output doutN, doutE, doutS, doutW, doutLocal, inj_ready, defl_cnt
  );
endinterface

// File: rtl/dec_rc_p.sv
// X-first route compute for one flit relative to this router's coordinates.
module dec_rc_p
  import dec_pkg::*;
#(
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int CORD_X = DEF_CORD_X,
  parameter int CORD_Y = DEF_CORD_Y
) (
  input  logic [X_W-1:0] dst_x,
  input  logic [Y_W-1:0] dst_y,
  output port_e          port
);
  localparam logic [X_W-1:0] CX = X_W'(CORD_X);
  localparam logic [Y_W-1:0] CY = Y_W'(CORD_Y);

  always_comb begin
    if (dst_x > CX)      port = PORT_E;
    else if (dst_x < CX) port = PORT_W;
    else if (dst_y > CY) port = PORT_N;
    else if (dst_y < CY) port = PORT_S;
    else                 port = PORT_L;
  end
endmodule

// File: rtl/dec_router_age.sv
// Two-stage bufferless deflection router: input registers, then age-ordered
// ejection / port allocation / crossbar into output registers.
module dec_router_age
  import dec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int CORD_X = DEF_CORD_X,
  parameter int CORD_Y = DEF_CORD_Y,
  parameter int AGE_W  = DEF_AGE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic             clk,
  input logic             reset,
  dec_router_age_if.slave bus
);
  localparam int FLIT_W = flit_w(DATA_W, AGE_W, X_W, Y_W);
  localparam int V_POS  = valid_pos(DATA_W, AGE_W, X_W, Y_W);
  localparam int AGE_LO = age_lo(DATA_W, X_W, Y_W);
  localparam int DX_LO  = dst_x_lo(DATA_W, Y_W);
  localparam int DY_LO  = dst_y_lo(DATA_W);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [FLIT_W-1:0] flit_t;

  flit_t din [4];
  flit_t s1 [4];
  flit_t dout_q [4];
  flit_t out_c [4];
  flit_t cand [5];
  flit_t local_q, ej_c, cur;
  port_e route [5];

  logic [2:0]       rank [5];
  logic [4:0]       cvld, ej_sel;
  logic [3:0]       busy;
  logic             ej_any, placed, ready_c;
  logic [2:0]       keep, defl_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_sum;
  logic             unused_inj_hdr;

  function automatic logic [AGE_W-1:0] age_of(flit_t f);
    return f[AGE_LO +: AGE_W];
  endfunction

  assign din[P_N] = bus.dinN;
  assign din[P_E] = bus.dinE;
  assign din[P_S] = bus.dinS;
  assign din[P_W] = bus.dinW;

  // The injected flit's own valid/age header is replaced on acceptance.
  assign unused_inj_hdr = ^bus.inj_flit[V_POS:AGE_LO];

  for (genvar g = 0; g < 5; g++) begin : g_rc
    flit_t rc_src;
    assign rc_src = (g < 4) ? s1[g % 4] : bus.inj_flit;
    dec_rc_p #(
      .X_W(X_W), .Y_W(Y_W), .CORD_X(CORD_X), .CORD_Y(CORD_Y)
    ) u_rc (
      .dst_x (rc_src[DX_LO +: X_W]),
      .dst_y (rc_src[DY_LO +: Y_W]),
      .port  (route[g])
    );
  end

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    ej_sel = '0;
    ej_any = 1'b0;
    ej_c   = '0;
    busy   = '0;
    defl_c = '0;
    placed = 1'b0;
    cur    = '0;
    for (int q = 0; q < 4; q++) out_c[q] = '0;

    // Rank = number of flits that beat this one (older, or same age on a lower port index).
    for (int i = 0; i < 4; i++) begin
      cand[i] = s1[i];
      cvld[i] = s1[i][V_POS];
      rank[i] = '0;
      for (int j = 0; j < 4; j++)
        if (j != i && (age_of(s1[j]) > age_of(s1[i]) ||
                       (age_of(s1[j]) == age_of(s1[i]) && j < i)))
          rank[i] = rank[i] + 3'd1;
    end

    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        if (rank[i] == 3'(r) && cvld[i] && route[i] == PORT_L && !ej_any) begin
          ej_any    = 1'b1;
          ej_sel[i] = 1'b1;
          ej_c      = s1[i];
        end

    keep    = 3'($countones(cvld[3:0])) - {2'b0, ej_any};
    ready_c = reset && (keep < 3'd4);

    cand[4] = {1'b1, {AGE_W{1'b0}}, bus.inj_flit[AGE_LO-1:0]};
    cvld[4] = bus.inj_valid && ready_c;
    rank[4] = 3'd4;

    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 5; i++)
        if (rank[i] == 3'(r) && cvld[i] && !ej_sel[i]) begin
          cur = cand[i];
          cur[AGE_LO +: AGE_W] = (age_of(cand[i]) == AGE_MAX) ? AGE_MAX
                                                              : age_of(cand[i]) + 1'b1;
          if (route[i] != PORT_L && !busy[route[i][1:0]]) begin
            busy[route[i][1:0]]  = 1'b1;
            out_c[route[i][1:0]] = cur;
          end else begin
            defl_c = defl_c + 3'd1;
            placed = 1'b0;
            for (int q = 0; q < 4; q++)
              if (!busy[q] && !placed) begin
                placed   = 1'b1;
                busy[q]  = 1'b1;
                out_c[q] = cur;
              end
          end
        end
  end

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(defl_c);

  always_ff @(posedge clk) begin
    // NOTE: the pipeline registers are cleared on reset so in-flight flits are discarded, not replayed.
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        s1[p]     <= '0;
        dout_q[p] <= '0;
      end
      local_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        s1[p]     <= din[p][V_POS] ? din[p] : '0;
        dout_q[p] <= out_c[p];
      end
      local_q <= ej_c;
      if (bus.defl_clr)         cnt_q <= '0;
      else if (cnt_sum[CNT_W])  cnt_q <= CNT_MAX;
      else                      cnt_q <= cnt_sum[CNT_W-1:0];
    end
  end

  assign bus.doutN     = dout_q[P_N];
  assign bus.doutE     = dout_q[P_E];
  assign bus.doutS     = dout_q[P_S];
  assign bus.doutW     = dout_q[P_W];
  assign bus.doutLocal = local_q;
  assign bus.inj_ready = ready_c;
  assign bus.defl_cnt  = cnt_q;
endmodule

// File: tb/tb_dec_router_age.sv
// Directed bench for dec_router_age at default parameters, router at (1,1).
module tb_dec_router_age;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dec_router_age_if #(.FLIT_W(41), .CNT_W(16)) bus ();

  dec_router_age dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [40:0] mk(input logic [3:0] age, input logic [1:0] x,
                                     input logic [1:0] y, input logic [31:0] pl);
    return {1'b1, age, x, y, pl};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dinN = '0; bus.dinE = '0; bus.dinS = '0; bus.dinW = '0;
    bus.inj_valid = 1'b0; bus.inj_flit = '0;
  endtask

  task automatic check_outs(input string tag, input logic [40:0] n, input logic [40:0] e,
                            input logic [40:0] s, input logic [40:0] w, input logic [40:0] l);
    check({tag, ".N"}, 64'(bus.doutN), 64'(n));
    check({tag, ".E"}, 64'(bus.doutE), 64'(e));
    check({tag, ".S"}, 64'(bus.doutS), 64'(s));
    check({tag, ".W"}, 64'(bus.doutW), 64'(w));
    check({tag, ".L"}, 64'(bus.doutLocal), 64'(l));
  endtask

  initial begin
    reset = 1'b0;
    bus.defl_clr = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check_outs("rst", '0, '0, '0, '0, '0);
    check("rst.cnt", 64'(bus.defl_cnt), 64'd0);
    check("rst.ready", 64'(bus.inj_ready), 64'd0);
    reset = 1'b1;
    tick();

    // Single W flit to (3,1) goes east; invalid S input with garbage stays silent.
    bus.dinW = mk(4'd2, 2'd3, 2'd1, 32'hCAFE_0001);
    bus.dinS = {1'b0, 40'hAB_CDEF_1234};
    tick();
    idle_inputs();
    tick();
    check_outs("single", '0, mk(4'd3, 2'd3, 2'd1, 32'hCAFE_0001), '0, '0, '0);
    check("single.cnt", 64'(bus.defl_cnt), 64'd0);

    // Older N flit wins E, younger S flit deflects to first free port N.
    bus.dinN = mk(4'd5, 2'd3, 2'd1, 32'h0000_00AA);
    bus.dinS = mk(4'd1, 2'd3, 2'd1, 32'h0000_00BB);
    tick();
    idle_inputs();
    tick();
    check_outs("age", mk(4'd2, 2'd3, 2'd1, 32'h0000_00BB),
               mk(4'd6, 2'd3, 2'd1, 32'h0000_00AA), '0, '0, '0);
    check("age.cnt", 64'(bus.defl_cnt), 64'd1);

    bus.defl_clr = 1'b1;
    tick();
    bus.defl_clr = 1'b0;
    check("clr", 64'(bus.defl_cnt), 64'd0);

    // Equal-age local flits: E beats W, W deflects out N.
    bus.dinE = mk(4'd3, 2'd1, 2'd1, 32'h0000_0D0D);
    bus.dinW = mk(4'd3, 2'd1, 2'd1, 32'h0000_0E0E);
    tick();
    idle_inputs();
    tick();
    check_outs("eject", mk(4'd4, 2'd1, 2'd1, 32'h0000_0E0E), '0, '0, '0,
               mk(4'd3, 2'd1, 2'd1, 32'h0000_0D0D));
    check("eject.cnt", 64'(bus.defl_cnt), 64'd1);

    // Four productive flits block injection; injection lands one cycle after acceptance.
    bus.dinN = mk(4'd0, 2'd1, 2'd3, 32'h0000_0001);
    bus.dinE = mk(4'd0, 2'd3, 2'd1, 32'h0000_0002);
    bus.dinS = mk(4'd0, 2'd1, 2'd0, 32'h0000_0003);
    bus.dinW = mk(4'd0, 2'd0, 2'd1, 32'h0000_0004);
    tick();
    idle_inputs();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(4'd0, 2'd2, 2'd1, 32'h0000_0F0F);
    #1;
    check("inj.blocked", 64'(bus.inj_ready), 64'd0);
    tick();
    check_outs("full", mk(4'd1, 2'd1, 2'd3, 32'h1), mk(4'd1, 2'd3, 2'd1, 32'h2),
               mk(4'd1, 2'd1, 2'd0, 32'h3), mk(4'd1, 2'd0, 2'd1, 32'h4), '0);
    check("inj.ready", 64'(bus.inj_ready), 64'd1);
    tick();
    idle_inputs();
    check_outs("inj", '0, mk(4'd1, 2'd2, 2'd1, 32'h0000_0F0F), '0, '0, '0);
    check("inj.cnt", 64'(bus.defl_cnt), 64'd1);

    // Age saturation on pass-through.
    bus.dinE = mk(4'd15, 2'd0, 2'd1, 32'h0000_5A5A);
    tick();
    idle_inputs();
    tick();
    check_outs("agesat", '0, '0, '0, mk(4'd15, 2'd0, 2'd1, 32'h0000_5A5A), '0);

    // Counter saturation: four local flits plus local injection give 4 deflections/cycle.
    bus.defl_clr = 1'b1;
    tick();
    bus.defl_clr = 1'b0;
    check("clr2", 64'(bus.defl_cnt), 64'd0);
    bus.dinN = mk(4'd0, 2'd1, 2'd1, 32'h0000_1111);
    bus.dinE = mk(4'd0, 2'd1, 2'd1, 32'h0000_2222);
    bus.dinS = mk(4'd0, 2'd1, 2'd1, 32'h0000_3333);
    bus.dinW = mk(4'd0, 2'd1, 2'd1, 32'h0000_4444);
    bus.inj_valid = 1'b1;
    bus.inj_flit  = mk(4'd0, 2'd1, 2'd1, 32'h0000_5555);
    tick();
    check("storm.cnt1", 64'(bus.defl_cnt), 64'd1);
    check("storm.out1", 64'(bus.doutN), 64'(mk(4'd1, 2'd1, 2'd1, 32'h0000_5555)));
    tick();
    check("storm.cnt2", 64'(bus.defl_cnt), 64'd5);
    check("storm.eject", 64'(bus.doutLocal), 64'(mk(4'd0, 2'd1, 2'd1, 32'h0000_1111)));
    for (int i = 0; i < 16400; i++) tick();
    check("cnt.sat", 64'(bus.defl_cnt), 64'hFFFF);
    idle_inputs();
    repeat (2) tick();
    check("cnt.hold", 64'(bus.defl_cnt), 64'hFFFF);
    bus.defl_clr = 1'b1;
    tick();
    bus.defl_clr = 1'b0;
    check("cnt.clr", 64'(bus.defl_cnt), 64'd0);
    repeat (2) tick();

    // Reset with flits in both stages discards them.
    bus.dinN = mk(4'd0, 2'd3, 2'd1, 32'h0000_7777);
    tick();
    bus.dinN = '0;
    bus.dinE = mk(4'd0, 2'd0, 2'd1, 32'h0000_8888);
    tick();
    idle_inputs();
    reset = 1'b0;
    tick();
    check_outs("rst2", '0, '0, '0, '0, '0);
    check("rst2.ready", 64'(bus.inj_ready), 64'd0);
    check("rst2.cnt", 64'(bus.defl_cnt), 64'd0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      check_outs("post", '0, '0, '0, '0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
